// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver for a common-anode seven-segment bank.
// Scans one digit per slot with a leading blank, snapshotting the word once per frame.
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS  = 8,
  parameter int unsigned DIV       = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic                    blank_lz,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              cc,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PcntMax = PW'(DIV - 1);
  localparam logic [IW-1:0] IdxMax  = IW'(N_DIGITS - 1);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [N_DIGITS-1:0]   an_d;
  logic [6:0]            cc_d;
  logic                  frame_tick_d;

  logic                  slot_end, frame_wrap, in_blank, digit_off;
  logic [3:0]            nibble;
  logic [N_DIGITS-1:0]   lz_mask;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A zero blank window must not produce a constant compare.
  if (BLANK_CYC == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (pcnt_q < PW'(BLANK_CYC));
  end

  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_mask    = '0;
    // Digit i is a leading zero when it and every digit above it are zero.
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (shadow_q[4*i +: 4] == 4'h0);
      lz_mask[i] = upper_zero && (i != 0);
    end
  end

  always_comb begin
    slot_end   = (pcnt_q == PcntMax);
    frame_wrap = slot_end && (idx_q == IdxMax);

    pcnt_d       = slot_end ? '0 : pcnt_q + PW'(1);
    idx_d        = idx_q;
    if (slot_end) idx_d = (idx_q == IdxMax) ? '0 : idx_q + IW'(1);
    shadow_d     = frame_wrap ? value : shadow_q;
    frame_tick_d = frame_wrap;

    nibble    = 4'(shadow_q >> {idx_q, 2'b00});
    digit_off = in_blank || (blank_lz && lz_mask[idx_q]);
    an_d      = digit_off ? '1 : ~(N_DIGITS'(1) << idx_q);
    cc_d      = digit_off ? 7'h7F : hex_seg(nibble);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      an         <= '1;
      cc         <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      an         <= an_d;
      cc         <= cc_d;
      dp         <= 1'b1;
      frame_tick <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (DIV=4/BLANK=1 and DIV=2/BLANK=0) checked each
// cycle against a cycle-count model of scan position, snapshot and leading-zero rules.
module tb_seg7_scan_driver;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value = '0;
  logic        blank_lz = 1'b0;

  logic [7:0] an_a, an_b;
  logic [6:0] cc_a, cc_b;
  logic       dp_a, dp_b, ft_a, ft_b;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(8), .DIV(4), .BLANK_CYC(1)) dut_a (
    .clk(clk), .reset(reset), .value(value), .blank_lz(blank_lz),
    .an(an_a), .cc(cc_a), .dp(dp_a), .frame_tick(ft_a)
  );

  seg7_scan_driver #(.N_DIGITS(8), .DIV(2), .BLANK_CYC(0)) dut_b (
    .clk(clk), .reset(reset), .value(value), .blank_lz(blank_lz),
    .an(an_b), .cc(cc_b), .dp(dp_b), .frame_tick(ft_b)
  );

  int n_pass = 0;
  int n_chk  = 0;
  string phase = "init";
  bit model_valid = 1'b0;

  // Model state: cycles elapsed within the current frame and the displayed word.
  int          kk [2];
  logic [31:0] sh [2];
  int          dv [2];
  int          bk [2];
  logic [6:0]  seg [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
  endtask

  task automatic step(input logic r, input logic [31:0] v, input logic b);
    logic [7:0] ean [2];
    logic [6:0] ecc [2];
    logic       eft [2];
    reset = r;
    value = v;
    blank_lz = b;
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      int fr, p, i;
      logic [31:0] upper;
      bit off;
      fr = dv[j] * N;
      if (r) begin
        ean[j] = 8'hFF; ecc[j] = 7'h7F; eft[j] = 1'b0;
        kk[j] = 0; sh[j] = '0;
      end else begin
        p = kk[j] % dv[j];
        i = kk[j] / dv[j];
        upper = sh[j] >> (4 * i);
        off = (p < bk[j]) || (b && i != 0 && upper == 0);
        ean[j] = off ? 8'hFF : ~(8'h01 << i);
        ecc[j] = off ? 7'h7F : seg[upper[3:0]];
        eft[j] = (kk[j] == fr - 1);
        kk[j] = (kk[j] + 1) % fr;
        if (kk[j] == 0) sh[j] = v;
      end
    end
    if (r) model_valid = 1'b1;
    #1;
    if (model_valid) begin
      chk("A.an", 32'(an_a), 32'(ean[0]));
      chk("A.cc", 32'(cc_a), 32'(ecc[0]));
      chk("A.dp", 32'(dp_a), 32'd1);
      chk("A.ft", 32'(ft_a), 32'(eft[0]));
      chk("B.an", 32'(an_b), 32'(ean[1]));
      chk("B.cc", 32'(cc_b), 32'(ecc[1]));
      chk("B.dp", 32'(dp_b), 32'd1);
      chk("B.ft", 32'(ft_b), 32'(eft[1]));
    end
  endtask

  initial begin
    logic [31:0] v;
    logic        b;
    logic        r;
    dv[0] = 4; bk[0] = 1;
    dv[1] = 2; bk[1] = 0;
    kk[0] = 0; kk[1] = 0;
    sh[0] = '0; sh[1] = '0;
    seg[0]  = 7'h40; seg[1]  = 7'h79; seg[2]  = 7'h24; seg[3]  = 7'h30;
    seg[4]  = 7'h19; seg[5]  = 7'h12; seg[6]  = 7'h02; seg[7]  = 7'h78;
    seg[8]  = 7'h00; seg[9]  = 7'h10; seg[10] = 7'h08; seg[11] = 7'h03;
    seg[12] = 7'h46; seg[13] = 7'h21; seg[14] = 7'h06; seg[15] = 7'h0E;

    phase = "reset";
    repeat (3) step(1'b1, 32'h0, 1'b0);

    phase = "scan";
    repeat (70) step(1'b0, 32'h89AB_CDEF, 1'b0);

    phase = "tear";
    repeat (40) step(1'b0, 32'h1111_1111, 1'b0);
    repeat (70) step(1'b0, 32'h2222_2222, 1'b0);

    phase = "lz";
    repeat (70) step(1'b0, 32'h0000_0A00, 1'b1);
    repeat (70) step(1'b0, 32'h0000_0000, 1'b1);

    phase = "rst_mid";
    step(1'b1, 32'h1234_5678, 1'b0);
    repeat (55) step(1'b0, 32'h1234_5678, 1'b0);
    step(1'b1, 32'h1234_5678, 1'b0);
    repeat (40) step(1'b0, 32'h1234_5678, 1'b0);

    phase = "rand";
    v = $urandom;
    b = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) v = $urandom & (32'hFFFF_FFFF >> (4 * $urandom_range(0, 7)));
      if ($urandom_range(0, 7) == 0) b = ~b;
      r = ($urandom_range(0, 99) == 0);
      step(r, v, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
